wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares one 8-bit-data, 4-bit-address Wishbone peripheral bus between N_CTRL byte-stream bridge controllers.
- Controllers issue single-cycle stb pulses. The arbiter captures each request, serialises the requests round-robin onto the peripheral bus, and routes ack, read data or timeout error back to the owning controller.
- Sits between the bridge controllers and the peripheral address decoder.

Parameters:
- N_CTRL, 2, number of requesting controllers (>=2).
- TIMEOUT, 255, cycles to wait for peri_ack_i after issue before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- ctrl_stb_i  in  N_CTRL  per-controller request pulse (one cycle).
- ctrl_we_i  in  N_CTRL  per-controller write enable, valid with stb.
- ctrl_adr_i  in  N_CTRL*4  per-controller address, slice i = [4i+3:4i].
- ctrl_dat_i  in  N_CTRL*8  per-controller write data, slice i = [8i+7:8i].
- ctrl_dat_o  out  8  read data, shared by all controllers, valid with ctrl_ack_o.
- ctrl_ack_o  out  N_CTRL  per-controller completion pulse.
- ctrl_err_o  out  N_CTRL  per-controller error pulse (overrun or timeout).
- peri_stb_o  out  1  peripheral strobe, one-cycle pulse.
- peri_we_o  out  1  peripheral write enable.
- peri_adr_o  out  4  peripheral address.
- peri_dat_o  out  8  peripheral write data.
- peri_dat_i  in  8  peripheral read data, valid with ack.
- peri_ack_i  in  1  peripheral acknowledge pulse.
- busy_o  out  1  high while state is not StIdle.

Behaviour:
- Reset (rst_ni=0 at posedge): all outputs 0, all pending slots cleared, rr pointer=0, state=StIdle, timeout counter=0. A reset mid-transfer drops the transfer with no ack or err; a peri_ack_i arriving after reset is ignored.
- Capture:
  - ctrl_stb_i[i]=1 with pending[i]=0 latches we/adr/dat into slot i and sets pending[i] at the same edge.
  - ctrl_stb_i[i]=1 with pending[i]=1 discards the request and pulses ctrl_err_o[i] on the next cycle.
- StIdle:
  - If any pending bit is set, the round-robin pick is the first set index at or after ptr, wrapping modulo N_CTRL.
  - Latch grant, peri_we_o, peri_adr_o and peri_dat_o from the picked slot; ptr <= (grant+1) mod N_CTRL; go to StIssue.
- StIssue: peri_stb_o=1 for exactly this cycle; timeout counter cleared; go to StWaitAck. A peri_ack_i sampled in this cycle completes the transfer (combinational-ack peripherals).
- StWaitAck: the counter increments each cycle.
  - On peri_ack_i: ctrl_dat_o <= peri_dat_i (also on writes); ctrl_ack_o[grant] pulses next cycle; pending[grant] cleared; go to StIdle.
  - If the counter reaches TIMEOUT without an ack: ctrl_err_o[grant] pulses next cycle, pending[grant] cleared, go to StIdle. A late ack is ignored.
- Latency: stb at cycle 0 into an idle arbiter → peri_stb_o at cycle 2; ack sampled at cycle k → ctrl_ack_o at cycle k+1. Back-to-back issue is possible at k+2.
- ctrl_dat_o holds its value until the next ack. peri_adr_o, peri_we_o and peri_dat_o hold until the next grant.
- peri_ack_i while in StIdle is ignored.
- Simultaneous events:
  - Several stb pulses in one cycle all capture.
  - A stb from the owner in the cycle its ack is sampled gives an overrun err.
  - A stb in the cycle after that (while ctrl_ack_o is high) is accepted.
- At most one of ctrl_ack_o/ctrl_err_o is high per controller per cycle, except an overrun err coinciding with the owner's completion; both pulses are then emitted.

Decomposition:
- Package wb_pkg:
  - WB_DATA_W=8 and WB_ADR_W=4.
  - state enum arb_state_e {StIdle, StIssue, StWaitAck}.
- Sub-module wb_rr_pick: combinational; inputs pending[N] and ptr; outputs a valid flag and the grant index.

Test Plan:
- Single read: ctrl0 stb, we=0, adr=4'h3 at cycle 0; peripheral acks at cycle 4 with 8'hA5 → peri_stb_o at cycle 2 only, peri_adr_o=3, ctrl_ack_o=2'b01 and ctrl_dat_o=A5 at cycle 5.
- Contention: ctrl0 write adr 1/dat 11 and ctrl1 write adr 2/dat 22 both stb at cycle 0, 1-cycle ack latency → ctrl0 issued first with ptr=0, then ctrl1. Repeating with ptr=1 issues ctrl1 first.
- Combinational ack: peri_ack_i is high during the StIssue cycle → ack pulse on the next cycle; the second queued request issues 2 cycles after the first strobe ends.
- Overrun: ctrl1 stb twice while its first request waits → ctrl_err_o=2'b10 one cycle after the second stb; the original request still completes with an ack.
- Timeout: TIMEOUT=4, no ack → ctrl_err_o[grant] pulses 5 cycles after peri_stb_o; a late ack 2 cycles later produces no ctrl_ack_o and busy_o stays 0.
- Reset mid-WaitAck: rst_ni low for 1 cycle, then ack → all outputs 0, no ack or err, pending empty, ptr=0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_pkg : bus widths, arbiter state encoding and request slot type        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package wb_pkg;

  localparam int WB_DATA_W = 8;
  localparam int WB_ADR_W  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWaitAck = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_ADR_W-1:0]  adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_rr_pick : first pending index at or after i_ptr, wrapping modulo N    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  i_pending,
  input  logic [GW-1:0] i_ptr,
  output logic          o_valid,
  output logic [GW-1:0] o_grant
);

  logic [GW-1:0] w_idx;

  // Walk from the farthest offset down so the nearest pending index wins.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = GW'((32'(i_ptr) + 32'(k)) % 32'(N));
      if (i_pending[w_idx]) begin
        o_valid = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_arbiter : round-robin sharing of one Wishbone peripheral bus          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_CTRL  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_CTRL-1:0]             ctrl_stb_i,
  input  logic [N_CTRL-1:0]             ctrl_we_i,
  input  logic [N_CTRL*WB_ADR_W-1:0]    ctrl_adr_i,
  input  logic [N_CTRL*WB_DATA_W-1:0]   ctrl_dat_i,
  output logic [WB_DATA_W-1:0]          ctrl_dat_o,
  output logic [N_CTRL-1:0]             ctrl_ack_o,
  output logic [N_CTRL-1:0]             ctrl_err_o,
  output logic                          peri_stb_o,
  output logic                          peri_we_o,
  output logic [WB_ADR_W-1:0]           peri_adr_o,
  output logic [WB_DATA_W-1:0]          peri_dat_o,
  input  logic [WB_DATA_W-1:0]          peri_dat_i,
  input  logic                          peri_ack_i,
  output logic                          busy_o
);

  localparam int c_grant_w = $clog2(N_CTRL);
  localparam int c_cnt_w   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e             r_state;
  arb_state_e             w_state_next;
  wb_req_t                r_slot [N_CTRL];
  wb_req_t                r_peri;
  logic [N_CTRL-1:0]      r_pending;
  logic [N_CTRL-1:0]      w_set;
  logic [N_CTRL-1:0]      w_clr;
  logic [c_grant_w-1:0]   r_ptr;
  logic [c_grant_w-1:0]   r_grant;
  logic [c_grant_w-1:0]   w_pick;
  logic                   w_pick_valid;
  logic [c_cnt_w-1:0]     r_cnt;
  logic                   w_timeout_hit;
  logic                   w_load;
  logic                   w_done_ack;
  logic                   w_done_to;
  logic [N_CTRL-1:0]      r_ack;
  logic [N_CTRL-1:0]      r_err;
  logic [WB_DATA_W-1:0]   r_dat;

  wb_rr_pick #(
    .N  (N_CTRL),
    .GW (c_grant_w)
  ) u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_valid   (w_pick_valid),
    .o_grant   (w_pick)
  );

  // A strobe only lands in a free slot; a strobe on a busy slot is an overrun.
  assign w_set = ctrl_stb_i & ~r_pending;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      assign w_timeout_hit = ((32'(r_cnt) + 32'd1) == 32'(TIMEOUT));
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done_ack   = 1'b0;
    w_done_to    = 1'b0;
    w_clr        = '0;
    case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_load       = 1'b1;
          w_state_next = StIssue;
        end
      end
      StIssue, StWaitAck: begin
        if (peri_ack_i) begin
          w_done_ack = 1'b1;
        end else if ((r_state == StWaitAck) && w_timeout_hit) begin
          w_done_to = 1'b1;
        end else begin
          w_state_next = StWaitAck;
        end
        if (w_done_ack || w_done_to) begin
          w_state_next   = StIdle;
          w_clr[r_grant] = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_CTRL; i++) begin
      if (!rst_ni) begin
        r_slot[i] <= '0;
      end else if (w_set[i]) begin
        r_slot[i] <= '{we:  ctrl_we_i[i],
                       adr: ctrl_adr_i[i*WB_ADR_W +: WB_ADR_W],
                       dat: ctrl_dat_i[i*WB_DATA_W +: WB_DATA_W]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pending <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_dat     <= '0;
      r_peri    <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_ack     <= '0;
      r_err     <= ctrl_stb_i & r_pending;
      if (w_load) begin
        r_grant <= w_pick;
        r_peri  <= r_slot[w_pick];
        r_ptr   <= (32'(w_pick) == N_CTRL - 1) ? '0 : w_pick + c_grant_w'(1);
      end
      if (r_state == StIssue) begin
        r_cnt <= '0;
      end else if (r_state == StWaitAck) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_done_ack) begin
        r_ack[r_grant] <= 1'b1;
        r_dat          <= peri_dat_i;
      end
      if (w_done_to) begin
        r_err[r_grant] <= 1'b1;
      end
    end
  end

  assign peri_stb_o = (r_state == StIssue);
  assign busy_o     = (r_state != StIdle);
  assign peri_we_o  = r_peri.we;
  assign peri_adr_o = r_peri.adr;
  assign peri_dat_o = r_peri.dat;
  assign ctrl_ack_o = r_ack;
  assign ctrl_err_o = r_err;
  assign ctrl_dat_o = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter : directed and random checks of wb_arbiter vs a ref model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_wb_arbiter;

  localparam int N  = 2;
  localparam int TO = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  stb   = '0;
  logic [1:0]  we    = '0;
  logic [7:0]  adr   = '0;
  logic [15:0] wdat  = '0;
  logic [7:0]  prdat = '0;
  logic        pack  = 1'b0;
  logic [7:0]  cdat;
  logic [1:0]  cack;
  logic [1:0]  cerr;
  logic        pstb;
  logic        pwe;
  logic [3:0]  padr;
  logic [7:0]  pdat;
  logic        busy;

  always #5 clk = ~clk;

  wb_arbiter #(
    .N_CTRL  (N),
    .TIMEOUT (TO)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ctrl_stb_i (stb),
    .ctrl_we_i  (we),
    .ctrl_adr_i (adr),
    .ctrl_dat_i (wdat),
    .ctrl_dat_o (cdat),
    .ctrl_ack_o (cack),
    .ctrl_err_o (cerr),
    .peri_stb_o (pstb),
    .peri_we_o  (pwe),
    .peri_adr_o (padr),
    .peri_dat_o (pdat),
    .peri_dat_i (prdat),
    .peri_ack_i (pack),
    .busy_o     (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: queue of one outstanding request per controller, the
  // current bus owner and the cycle its strobe appears on the bus.
  bit         m_pend [N];
  bit         m_we   [N];
  logic [3:0] m_adr  [N];
  logic [7:0] m_dat  [N];
  int         m_ptr, m_owner, m_issue;
  logic [1:0] e_ack, e_err;
  logic [7:0] e_dat, e_pdat;
  logic       e_we;
  logic [3:0] e_adr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_we[i]   = 1'b0;
      m_adr[i]  = '0;
      m_dat[i]  = '0;
    end
    m_ptr = 0; m_owner = -1; m_issue = -1;
    e_ack = '0; e_err = '0; e_dat = '0; e_pdat = '0; e_we = 1'b0; e_adr = '0;
  endtask

  task automatic model_step();
    bit         old [N];
    logic [1:0] nack;
    logic [1:0] nerr;
    bit         found;
    int         j;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old  = m_pend;
    nack = '0;
    nerr = '0;
    for (int i = 0; i < N; i++) if (stb[i] && old[i]) nerr[i] = 1'b1;
    if (m_owner >= 0) begin
      if (pack) begin
        nack[m_owner]   = 1'b1;
        e_dat           = prdat;
        m_pend[m_owner] = 1'b0;
        m_owner         = -1;
      end else if (cyc - m_issue == TO) begin
        nerr[m_owner]   = 1'b1;
        m_pend[m_owner] = 1'b0;
        m_owner         = -1;
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && old[j]) begin
          found   = 1'b1;
          m_owner = j;
          m_issue = cyc + 1;
          e_we    = m_we[j];
          e_adr   = m_adr[j];
          e_pdat  = m_dat[j];
        end
      end
      if (found) m_ptr = (m_owner + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (stb[i] && !old[i]) begin
        m_pend[i] = 1'b1;
        m_we[i]   = we[i];
        m_adr[i]  = adr[4*i +: 4];
        m_dat[i]  = wdat[8*i +: 8];
      end
    end
    e_ack = nack;
    e_err = nerr;
  endtask

  task automatic check_outputs();
    chk("m_ack",  16'(cack), 16'(e_ack));
    chk("m_err",  16'(cerr), 16'(e_err));
    chk("m_cdat", 16'(cdat), 16'(e_dat));
    chk("m_pstb", 16'(pstb), 16'((m_owner >= 0) && (cyc == m_issue)));
    chk("m_busy", 16'(busy), 16'(m_owner >= 0));
    chk("m_pwe",  16'(pwe),  16'(e_we));
    chk("m_padr", 16'(padr), 16'(e_adr));
    chk("m_pdat", 16'(pdat), 16'(e_pdat));
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    stb   = '0;
    pack  = 1'b0;
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for the next strobe, checks its address, acks after lat cycles.
  task automatic serve(input int lat, input logic [7:0] d, input logic [3:0] exp_adr);
    int n = 0;
    while (!pstb && n < 12) begin
      tick();
      n++;
    end
    chk("issue_seen", 16'(pstb), 16'd1);
    chk("issue_adr",  16'(padr), 16'(exp_adr));
    repeat (lat) tick();
    pack  = 1'b1;
    prdat = d;
    tick();
  endtask

  initial begin
    int s;
    int ack_at;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",  16'(cack), 16'd0);
    chk("rst_err",  16'(cerr), 16'd0);
    chk("rst_cdat", 16'(cdat), 16'd0);
    chk("rst_pstb", 16'(pstb), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_padr", 16'(padr), 16'd0);
    rst_n = 1'b1;

    // Single read from ctrl0.
    stb = 2'b01; we = 2'b00; adr = 8'h03;
    tick(); tick();
    chk("rd_pstb", 16'(pstb), 16'd1);
    chk("rd_padr", 16'(padr), 16'd3);
    tick(); tick();
    pack = 1'b1; prdat = 8'hA5;
    tick();
    chk("rd_ack",  16'(cack), 16'b01);
    chk("rd_cdat", 16'(cdat), 16'hA5);
    tick();

    // Contention with ptr=1: ctrl1 goes first.
    stb = 2'b11; we = 2'b11; adr = 8'h21; wdat = 16'h2211;
    tick();
    serve(1, 8'h5A, 4'h2);
    chk("ct1_ack1", 16'(cack), 16'b10);
    serve(1, 8'h6B, 4'h1);
    chk("ct1_ack0", 16'(cack), 16'b01);
    tick();

    // Overrun from ctrl1, including a strobe in its own ack cycle.
    stb = 2'b10; we = 2'b00; adr = 8'h50;
    tick(); tick(); tick();
    stb = 2'b10;
    tick();
    chk("ovr_err", 16'(cerr), 16'b10);
    pack = 1'b1; prdat = 8'h3C; stb = 2'b10;
    tick();
    chk("ovr_ack_and_err", 16'({cack, cerr}), 16'b1010);
    stb = 2'b10; adr = 8'h70;
    tick();
    serve(2, 8'h44, 4'h7);
    chk("ovr_reissue_ack", 16'(cack), 16'b10);
    tick();

    // Timeout on ctrl0 and a late ack that must be ignored.
    stb = 2'b01; adr = 8'h09;
    tick();
    s = 0;
    while (!pstb && s < 12) begin tick(); s++; end
    chk("to_issue", 16'(pstb), 16'd1);
    repeat (5) tick();
    chk("to_err", 16'(cerr), 16'b01);
    tick(); tick();
    pack = 1'b1;
    tick();
    chk("to_late_ack",  16'(cack), 16'd0);
    chk("to_late_busy", 16'(busy), 16'd0);

    // Reset while waiting for an ack.
    stb = 2'b01; adr = 8'h0E;
    tick();
    s = 0;
    while (!pstb && s < 12) begin tick(); s++; end
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_outs", 16'({cack, cerr, cdat, padr}), 16'd0);
    pack = 1'b1;
    tick();
    chk("post_rst_ack",  16'(cack), 16'd0);
    chk("post_rst_busy", 16'(busy), 16'd0);

    // Contention with ptr=0 after reset: ctrl0 first.
    stb = 2'b11; we = 2'b11; adr = 8'h21; wdat = 16'h2211;
    tick();
    serve(1, 8'h01, 4'h1);
    serve(1, 8'h02, 4'h2);
    tick();

    // Combinational ack: second request issues two cycles after the first strobe.
    stb = 2'b11; we = 2'b00; adr = 8'hB4;
    tick();
    serve(0, 8'hC3, 4'h4);
    chk("cmb_ack", 16'(cack), 16'b01);
    tick();
    chk("cmb_second_issue", 16'(pstb), 16'd1);
    pack = 1'b1; prdat = 8'hD2;
    tick();
    chk("cmb_second_ack", 16'(cack), 16'b10);
    tick();

    // Random traffic with a randomly delayed responder and rare resets.
    ack_at = -1;
    for (int t = 0; t < 800; t++) begin
      if (pstb) ack_at = cyc + int'($urandom_range(0, 6));
      stb   = 2'($urandom) & 2'($urandom);
      we    = 2'($urandom);
      adr   = 8'($urandom);
      wdat  = 16'($urandom);
      prdat = 8'($urandom);
      pack  = (cyc == ack_at) || ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
